execute: RTL and testbench

Decode/execute stage of the 4-bit TD4-class CPU, sitting directly downstream of the fetch stage. It consumes the 8-bit instruction word for the current PC and holds the architectural state: registers A and B, output latch OUT, and carry flag C. It executes one instruction per clock and returns the branch decision (`isjump`) and target (`jumpadrs`) to fetch in the same cycle.

---
 rtl/execute_if.sv | 29 ++
 rtl/execute.sv | 143 ++++++++++++++
 tb/tb_execute.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/execute_if.sv
// ============================================================================
//  Module      : execute_if
//  Description : Fetch <-> execute link for the 4-bit TD4-class CPU: the
//                instruction word and the same-cycle branch decision.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface execute_if;
    logic [7:0] inst;
    logic [3:0] jumpadrs;
    logic       isjump;

    // Fetch side: supplies the instruction and consumes the branch decision.
    modport master (
        output inst,
        input  jumpadrs,
        input  isjump
    );

    // Execute side: decodes the instruction and returns the branch decision.
    modport slave (
        input  inst,
        output jumpadrs,
        output isjump
    );
endinterface

`default_nettype wire

// File: rtl/execute.sv
// ============================================================================
//  Module      : execute
//  Description : Decode/execute stage of the 4-bit TD4-class CPU. Holds A, B,
//                OUT and carry; executes one instruction per clock.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module execute (
    input  wire logic       clk,
    input  wire logic       rst,        // asynchronous, active-low
    execute_if.slave        fetch,
    input  wire logic [3:0] inport,
    output logic      [3:0] outport,
    output logic      [3:0] rega,
    output logic      [3:0] regb,
    output logic            carry
);

    localparam logic [3:0] c_op_add_a  = 4'b0000;
    localparam logic [3:0] c_op_mov_ab = 4'b0001;
    localparam logic [3:0] c_op_in_a   = 4'b0010;
    localparam logic [3:0] c_op_mov_a  = 4'b0011;
    localparam logic [3:0] c_op_mov_ba = 4'b0100;
    localparam logic [3:0] c_op_add_b  = 4'b0101;
    localparam logic [3:0] c_op_in_b   = 4'b0110;
    localparam logic [3:0] c_op_mov_b  = 4'b0111;
    localparam logic [3:0] c_op_out_b  = 4'b1001;
    localparam logic [3:0] c_op_out_im = 4'b1011;
    localparam logic [3:0] c_op_jnc    = 4'b1110;
    localparam logic [3:0] c_op_jmp    = 4'b1111;

    typedef enum logic [1:0] {
        SRC_ZERO = 2'd0,
        SRC_A    = 2'd1,
        SRC_B    = 2'd2,
        SRC_IN   = 2'd3
    } src_e;

    typedef enum logic [1:0] {
        DST_NONE = 2'd0,
        DST_A    = 2'd1,
        DST_B    = 2'd2,
        DST_OUT  = 2'd3
    } dst_e;

    logic [3:0] opcode;
    logic [3:0] imm;
    src_e       src_sel;
    dst_e       dst_sel;
    logic [3:0] src_val;
    logic [4:0] sum;
    logic       jump;

    logic [3:0] rega_q,  rega_d;
    logic [3:0] regb_q,  regb_d;
    logic [3:0] out_q,   out_d;
    logic       carry_q, carry_d;

    assign opcode = fetch.inst[7:4];
    assign imm    = fetch.inst[3:0];

    // Every writing instruction is "dst <- src + Im"; decode reduces to a
    // source/destination pair. Jumps and undefined opcodes write nothing.
    always_comb begin
        src_sel = SRC_ZERO;
        dst_sel = DST_NONE;
        case (opcode)
            c_op_add_a:  begin src_sel = SRC_A;    dst_sel = DST_A;   end
            c_op_mov_ab: begin src_sel = SRC_B;    dst_sel = DST_A;   end
            c_op_in_a:   begin src_sel = SRC_IN;   dst_sel = DST_A;   end
            c_op_mov_a:  begin src_sel = SRC_ZERO; dst_sel = DST_A;   end
            c_op_mov_ba: begin src_sel = SRC_A;    dst_sel = DST_B;   end
            c_op_add_b:  begin src_sel = SRC_B;    dst_sel = DST_B;   end
            c_op_in_b:   begin src_sel = SRC_IN;   dst_sel = DST_B;   end
            c_op_mov_b:  begin src_sel = SRC_ZERO; dst_sel = DST_B;   end
            c_op_out_b:  begin src_sel = SRC_B;    dst_sel = DST_OUT; end
            c_op_out_im: begin src_sel = SRC_ZERO; dst_sel = DST_OUT; end
            default:     begin src_sel = SRC_ZERO; dst_sel = DST_NONE; end
        endcase
    end

    always_comb begin
        src_val = 4'd0;
        case (src_sel)
            SRC_ZERO: src_val = 4'd0;
            SRC_A:    src_val = rega_q;
            SRC_B:    src_val = regb_q;
            SRC_IN:   src_val = inport;
            default:  src_val = 4'd0;
        endcase
    end

    assign sum = {1'b0, src_val} + {1'b0, imm};

    // Carry only survives one instruction: non-writing opcodes clear it.
    always_comb begin
        rega_d  = rega_q;
        regb_d  = regb_q;
        out_d   = out_q;
        carry_d = 1'b0;
        case (dst_sel)
            DST_A:   begin rega_d = sum[3:0]; carry_d = sum[4]; end
            DST_B:   begin regb_d = sum[3:0]; carry_d = sum[4]; end
            DST_OUT: begin out_d  = sum[3:0]; carry_d = sum[4]; end
            default: carry_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rega_q  <= 4'd0;
            regb_q  <= 4'd0;
            out_q   <= 4'd0;
            carry_q <= 1'b0;
        end else begin
            rega_q  <= rega_d;
            regb_q  <= regb_d;
            out_q   <= out_d;
            carry_q <= carry_d;
        end
    end

    // JNC tests the carry left by the previous instruction.
    always_comb begin
        jump = 1'b0;
        if (opcode == c_op_jmp)
            jump = 1'b1;
        else if (opcode == c_op_jnc)
            jump = ~carry_q;
    end

    assign fetch.isjump   = jump;
    assign fetch.jumpadrs = imm;

    assign outport = out_q;
    assign rega    = rega_q;
    assign regb    = regb_q;
    assign carry   = carry_q;

endmodule

`default_nettype wire

// File: tb/tb_execute.sv
// ============================================================================
//  Module      : tb_execute
//  Description : Self-checking bench for execute: reference model feeds a
//                scoreboard queue that is drained after each executing edge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_execute;

    logic       clk;
    logic       rst;
    logic [3:0] inport;
    logic [3:0] outport;
    logic [3:0] rega;
    logic [3:0] regb;
    logic       carry;

    execute_if u_if ();

    execute u_dut (
        .clk     (clk),
        .rst     (rst),
        .fetch   (u_if.slave),
        .inport  (inport),
        .outport (outport),
        .rega    (rega),
        .regb    (regb),
        .carry   (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] o;
        logic       c;
    } exp_t;

    exp_t sb_q[$];

    int n_cmp;
    int n_err;

    // Reference architectural state
    logic [3:0] m_a, m_b, m_o;
    logic       m_c;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_a = 4'd0; m_b = 4'd0; m_o = 4'd0; m_c = 1'b0;
    endtask

    task automatic model_exec(input logic [7:0] ins, input logic [3:0] inp);
        logic [4:0] r;
        logic [3:0] im;
        im = ins[3:0];
        case (ins[7:4])
            4'h0: begin r = m_a + im;  m_a = r[3:0]; m_c = r[4]; end
            4'h5: begin r = m_b + im;  m_b = r[3:0]; m_c = r[4]; end
            4'h3: begin m_a = im; m_c = 1'b0; end
            4'h7: begin m_b = im; m_c = 1'b0; end
            4'h1: begin r = m_b + im;  m_a = r[3:0]; m_c = r[4]; end
            4'h4: begin r = m_a + im;  m_b = r[3:0]; m_c = r[4]; end
            4'h2: begin r = inp + im;  m_a = r[3:0]; m_c = r[4]; end
            4'h6: begin r = inp + im;  m_b = r[3:0]; m_c = r[4]; end
            4'h9: begin r = m_b + im;  m_o = r[3:0]; m_c = r[4]; end
            4'hB: begin m_o = im; m_c = 1'b0; end
            default: m_c = 1'b0;
        endcase
    endtask

    task automatic check_state(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 8'd1, 8'd0);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_a"},   {4'd0, rega},    {4'd0, e.a});
            check({tag, "_b"},   {4'd0, regb},    {4'd0, e.b});
            check({tag, "_out"}, {4'd0, outport}, {4'd0, e.o});
            check({tag, "_c"},   {7'd0, carry},   {7'd0, e.c});
        end
    endtask

    // One instruction: check the branch decision, then the committed state.
    task automatic step(input string tag, input logic [7:0] ins, input logic [3:0] inp);
        logic exp_jump;
        exp_t e;
        @(negedge clk);
        u_if.inst = ins;
        inport    = inp;
        #1;
        exp_jump = (ins[7:4] == 4'hF) || ((ins[7:4] == 4'hE) && !m_c);
        check({tag, "_isjump"},   {7'd0, u_if.isjump},   {7'd0, exp_jump});
        check({tag, "_jumpadrs"}, {4'd0, u_if.jumpadrs}, {4'd0, ins[3:0]});
        model_exec(ins, inp);
        e.a = m_a; e.b = m_b; e.o = m_o; e.c = m_c;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        check_state(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst       = 1'b0;
        u_if.inst = 8'h3F;
        inport    = 4'h0;
        model_reset();

        // Reset holds state at zero despite clocking a MOV A,F
        repeat (3) @(posedge clk);
        #1;
        check("rst_a",   {4'd0, rega},    8'h00);
        check("rst_b",   {4'd0, regb},    8'h00);
        check("rst_out", {4'd0, outport}, 8'h00);
        check("rst_c",   {7'd0, carry},   8'h00);
        u_if.inst = 8'hE5;
        #1;
        check("rst_jnc_taken", {7'd0, u_if.isjump}, 8'h01);

        @(negedge clk);
        rst = 1'b1;

        step("mov_a_f",  8'h3F, 4'h0);
        check("plan_a_f", {4'd0, rega}, 8'h0F);
        step("add_ovf",  8'h01, 4'h0);
        check("plan_carry_set", {7'd0, carry}, 8'h01);
        step("jnc_c1",   8'hE5, 4'h0);
        step("mov_a_2",  8'h32, 4'h0);
        step("add_nc",   8'h00, 4'h0);
        step("jnc_c0",   8'hE5, 4'h0);
        step("jmp",      8'hF9, 4'h0);
        step("in_b",     8'h60, 4'h6);
        check("plan_b_6", {4'd0, regb}, 8'h06);
        step("out_b",    8'h91, 4'h0);
        check("plan_out_7", {4'd0, outport}, 8'h07);
        step("out_im",   8'hBA, 4'h0);
        step("mov_a_3",  8'h33, 4'h0);
        step("mov_ba",   8'h40, 4'h0);
        step("mov_ab",   8'h10, 4'h0);
        step("undef",    8'h8F, 4'h0);
        step("in_a_ovf", 8'h2C, 4'h9);
        step("add_b_ovf",8'h5F, 4'h0);
        step("undef_a",  8'hA3, 4'h0);
        step("mov_b_e",  8'h7E, 4'h0);
        step("out_b_ovf",8'h93, 4'h0);
        step("jnc_after",8'hE7, 4'h0);

        for (int i = 0; i < 60; i++) begin
            step("rand", 8'($urandom), 4'($urandom_range(0, 15)));
        end

        // Reset mid-cycle, away from any clock edge
        step("pre_rst", 8'h3D, 4'h0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("async_a",   {4'd0, rega},    8'h00);
        check("async_b",   {4'd0, regb},    8'h00);
        check("async_out", {4'd0, outport}, 8'h00);
        check("async_c",   {7'd0, carry},   8'h00);
        @(negedge clk);
        rst = 1'b1;
        step("post_rst_in",  8'h24, 4'h5);
        step("post_rst_out", 8'h90, 4'h0);

        check("sb_drained", 8'(sb_q.size()), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
